mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the 5-stage MIPS pipeline. Consumes the EX/MEM pipeline register outputs and resolves branches for the PC mux. Owns the data memory and a wait-state FSM that stalls upstream for multi-cycle accesses. Registers the MEM/WB pipeline register that feeds write-back.

## Interface
- DEPTH, 1024, data memory size in 32-bit words (power of two); ADDR_W = log2(DEPTH)
- MEM_LATENCY, 2, cycles per load/store (1..8)

- clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- BranchAddResultIn  in  32  branch target from EX/MEM
- ALUResultIn  in  32  memory byte address / ALU result
- MemDataIn  in  32  store data
- rdRegIn  in  5  destination register
- RegWriteIn, MemWriteIn, MemReadIn, MemToRegIn, ZeroIn  in  1 each  control from EX/MEM
- BranchIn  in  2  00 none, 01 beq, 10 bne, 11 unconditional
- MemSizeIn  in  2  access size (used only with MEM_SUBWORD_EN)
- PCSrcOut  out  1  take branch (combinational)
- BranchTargetOut  out  32  = BranchAddResultIn (combinational)
- StallOut  out  1  hold IF/ID/EX and EX/MEM (combinational)
- ReadDataOut, ALUResultOut  out  32 each  MEM/WB register
- rdRegOut  out  5  MEM/WB register
- RegWriteOut, MemToRegOut  out  1 each  MEM/WB register

One clock; reset is synchronous and active-high.

## Operation
- Branch: PCSrcOut = (Branch==01 & Zero) | (Branch==10 & ~Zero) | (Branch==11); forced 0 while Reset.
- Access = MemReadIn | MemWriteIn. Both high: treated as store; ReadDataOut returns pre-write word.
- Word index = ALUResultIn[ADDR_W+1:2]; higher bits ignored (wraps), bits [1:0] ignored for word access.
- FSM states IDLE, ACCESS; down-counter cnt (3 bits).
  - IDLE, no access or MEM_LATENCY==1: StallOut=0; store commits and load captures at this edge; MEM/WB loads.
  - IDLE, access, MEM_LATENCY>1: StallOut=1, cnt<=MEM_LATENCY-2, ->ACCESS; MEM/WB loads bubble (RegWriteOut=0, MemToRegOut=0, other fields hold).
  - ACCESS, cnt!=0: StallOut=1, cnt<=cnt-1, bubble into MEM/WB.
  - ACCESS, cnt==0: StallOut=0, store commits exactly once, load captured, MEM/WB loads real instruction, ->IDLE.
- Upstream holds all *In signals stable while StallOut=1.
- Non-memory instructions never stall.

## Timing
- Reset: state IDLE, cnt 0, all MEM/WB outputs 0, StallOut 0; memory contents unchanged.
- Reset during ACCESS: pending store aborted (no write), state IDLE next cycle.
- Access accepted cycle t: StallOut high cycles t..t+L-2; commit edge at end of cycle t+L-1; MEM/WB valid cycle t+L.
- Back-to-back accesses: second enters IDLE cycle t+L, no idle gap beyond latency.
- Memory read is synchronous (captured at completion edge into ReadDataOut); no combinational memory-to-output path.

## Configuration
- MEM_SUBWORD_EN defined: MemSizeIn 00 word, 01 halfword (sign-extended, ALUResultIn[1] selects half, little-endian), 10 byte (sign-extended, ALUResultIn[1:0] selects lane), 11 byte zero-extended; stores write only the selected byte lanes from MemDataIn low bits.
- Undefined: MemSizeIn ignored; all accesses full 32-bit words.

## Test plan
- Reset then idle: all outputs 0, StallOut 0 for 5 cycles.
- L=2: sw 0xDEADBEEF to 0x40, then lw 0x40 rdReg=8: StallOut high 1 cycle each; ReadDataOut=0xDEADBEEF, RegWriteOut=1, rdRegOut=8 at cycle t+2 of load.
- Branch: Branch=01 Zero=1 -> PCSrcOut=1, BranchTargetOut=BranchAddResultIn; Branch=10 Zero=1 -> 0; Branch=11 -> 1.
- Reset asserted mid-store (L=4, cycle t+1): later load of that address returns prior contents; StallOut 0 after reset edge.
- Address 0x1000 with DEPTH=1024 aliases 0x0000: store to one, load from other matches.
- MEM_SUBWORD_EN: word 0x80FF7F01 at 0x20; lb 0x21 -> 0x0000007F, lb 0x23 -> 0xFFFFFF80, lh 0x22 -> 0xFFFF80FF, sb 0xAA to 0x20 -> word 0x80FF7FAA.

Source files
------------

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: branch resolve, wait-state data memory, MEM/WB register.
// Optional macro MEM_SUBWORD_EN enables byte/halfword loads and stores.
module mem_access_stage #(
    parameter int DEPTH       = 1024,
    parameter int MEM_LATENCY = 2,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] BranchAddResultIn,
    input  logic [31:0] ALUResultIn,
    input  logic [31:0] MemDataIn,
    input  logic [4:0]  rdRegIn,
    input  logic        RegWriteIn,
    input  logic        MemWriteIn,
    input  logic        MemReadIn,
    input  logic        MemToRegIn,
    input  logic        ZeroIn,
    input  logic [1:0]  BranchIn,
    input  logic [1:0]  MemSizeIn,
    output logic        PCSrcOut,
    output logic [31:0] BranchTargetOut,
    output logic        StallOut,
    output logic [31:0] ReadDataOut,
    output logic [31:0] ALUResultOut,
    output logic [4:0]  rdRegOut,
    output logic        RegWriteOut,
    output logic        MemToRegOut
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam bit         MULTI  = (MEM_LATENCY > 1);
    localparam logic [2:0] CNT_LD = 3'(MEM_LATENCY >= 2 ? MEM_LATENCY - 2 : 0);

    state_t      state, stateNext;
    logic [2:0]  cnt, cntNext;
    logic        access, complete, wrEn;
    logic [ADDR_W-1:0] wordIdx;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdWord, loadData, wrData;
    logic [3:0]  byteEn;

    assign access          = MemReadIn | MemWriteIn;
    assign wordIdx         = ALUResultIn[ADDR_W+1:2];
    assign BranchTargetOut = BranchAddResultIn;

    always_comb begin
        PCSrcOut = 1'b0;
        if (!Reset)
            PCSrcOut = ((BranchIn == 2'b01) &  ZeroIn) |
                       ((BranchIn == 2'b10) & ~ZeroIn) |
                        (BranchIn == 2'b11);
    end

    // Wait-state FSM: complete marks the edge where the instruction retires into MEM/WB.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        StallOut  = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (access && MULTI) begin
                    StallOut  = 1'b1;
                    cntNext   = CNT_LD;
                    stateNext = ACCESS;
                end else begin
                    complete = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt != 3'd0) begin
                    StallOut = 1'b1;
                    cntNext  = 3'(cnt - 3'd1);
                end else begin
                    complete  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (Reset) begin
            StallOut = 1'b0;
            complete = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    assign rdWord = mem[wordIdx];
    assign wrEn   = complete & MemWriteIn;

`ifdef MEM_SUBWORD_EN
    logic [15:0] half;
    logic [7:0]  lane;

    always_comb begin
        half     = ALUResultIn[1] ? rdWord[31:16] : rdWord[15:0];
        lane     = rdWord[8*ALUResultIn[1:0] +: 8];
        loadData = rdWord;
        byteEn   = 4'hF;
        wrData   = MemDataIn;
        case (MemSizeIn)
            2'b01: begin
                loadData = {{16{half[15]}}, half};
                byteEn   = ALUResultIn[1] ? 4'b1100 : 4'b0011;
                wrData   = {2{MemDataIn[15:0]}};
            end
            2'b10: begin
                loadData = {{24{lane[7]}}, lane};
                byteEn   = 4'b0001 << ALUResultIn[1:0];
                wrData   = {4{MemDataIn[7:0]}};
            end
            2'b11: begin
                loadData = {24'd0, lane};
                byteEn   = 4'b0001 << ALUResultIn[1:0];
                wrData   = {4{MemDataIn[7:0]}};
            end
            default: ;
        endcase
    end
`else
    logic unusedSize;
    assign unusedSize = ^MemSizeIn;
    assign loadData   = rdWord;
    assign byteEn     = 4'hF;
    assign wrData     = MemDataIn;
`endif

    // Memory is never reset; contents survive Reset by design.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < 4; b++)
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
        end
    end

    // Stall cycles push a bubble: only the write-enables drop, data fields hold.
    always_ff @(posedge clk) begin
        if (Reset) begin
            ReadDataOut  <= 32'd0;
            ALUResultOut <= 32'd0;
            rdRegOut     <= 5'd0;
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
        end else if (complete) begin
            ReadDataOut  <= MemReadIn ? loadData : 32'd0;
            ALUResultOut <= ALUResultIn;
            rdRegOut     <= rdRegIn;
            RegWriteOut  <= RegWriteIn;
            MemToRegOut  <= MemToRegIn;
        end else begin
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
        end
    end

endmodule
